vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: H_START, default 144, first active-pixel x; V_START, default 35, first active line y.
REQ-002 SHALL have parameters: FB_W, default 160, framebuffer width in pixels; FB_H, default 120, framebuffer height in pixels; SCALE_LOG2, default 2, 4x4 pixel replication.
REQ-003 SHALL have ports: clk_25mhz  in  1  pixel clock, single clock domain.
REQ-004 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: x  in  10  horizontal counter (0..799, from the line timer); y  in  10  vertical line counter (0..524).
REQ-006 SHALL have ports: cpu_req  in  1  request, held until acked; cpu_we  in  1  1=write; cpu_addr  in  15  pixel address; cpu_wdata  in  8  write data.
REQ-007 SHALL have ports: cpu_ack  out  1  one-cycle grant pulse; cpu_rvalid  out  1  read-data strobe; cpu_rdata  out  8  read data.
REQ-008 SHALL have ports: mem_addr  out  15; mem_we  out  1; mem_wdata  out  8; mem_rdata  in  8  single-port sync RAM, 1-cycle read latency.
REQ-009 SHALL have ports: pix_out  out  8  pixel colour to the DAC.

Function
REQ-010 SHALL define the fetch window as x in [H_START-4, H_START+636) with y in [V_START, V_START+480); fetch phase f = x-(H_START-4).
REQ-011 SHALL treat a cycle as a display slot when it is inside the fetch window and f[1:0]==0; the RAM is driven with mem_addr = row*FB_W + col, where row=(y-V_START)>>2 and col=f>>2, and mem_we=0.
REQ-012 SHALL compute row*160 as (row<<7)+(row<<5) in 15 bits, with no multiplier.
REQ-013 SHALL latch mem_rdata into a pending register one cycle after each display slot.
REQ-014 SHALL load pix_out from the pending register when (x-H_START)[1:0]==0 inside the active region; pix_out SHALL be 0 for the entire cycle range outside the active region.
REQ-015 SHALL use a three-state FSM: IDLE, DISP (display slot), CPU (grant cycle); the state is re-evaluated every cycle.
REQ-016 SHALL give the display slot absolute priority: when cpu_req coincides with a display slot, the state is DISP and cpu_ack=0.
REQ-017 SHALL enter CPU on any non-display cycle with cpu_req=1 and cpu_ack=0 in the previous cycle; cpu_ack=1 in that cycle only.
REQ-018 In a CPU grant cycle, SHALL drive mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
REQ-019 SHALL never grant the CPU on back-to-back cycles; the requester drops or changes cpu_req after cpu_ack.
REQ-020 For a CPU read, SHALL assert cpu_rvalid exactly one cycle after cpu_ack, with cpu_rdata=mem_rdata.
REQ-021 SHALL use a 1-bit owner tag to route returning mem_rdata to either the pending register or cpu_rdata, never both.
REQ-022 For cpu_addr >= FB_W*FB_H (19200), SHALL still assert cpu_ack, force mem_we=0, and on a read return cpu_rdata=0 with cpu_rvalid=1.
REQ-023 SHALL guarantee a CPU worst-case wait of 2 cycles in the active region and 1 cycle elsewhere.
REQ-024 Outside display slots with no request, SHALL drive mem_we=0; mem_addr holds its last value.

Reset
REQ-025 While rst=1, SHALL force state=IDLE, cpu_ack=0, cpu_rvalid=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_out=0, the pending register to 0 and the owner tag to display.
REQ-026 Reset asserted mid-transaction SHALL drop the in-flight read (no cpu_rvalid); after reset releases, a request still held is re-arbitrated.
REQ-027 Reset SHALL be asynchronous on assertion; the first grant is possible on the first clock edge after release.

Structure
REQ-028 SHALL take H_START, V_START, FB_W, FB_H and the active sizes from a shared package vga_timing_pkg, which also holds the FSM state encoding.
REQ-029 SHALL implement the row/col-to-address arithmetic (REQ-012) in a sub-module fb_addr_gen.

Verification
REQ-030 Blanking write: y=10, cpu_req, we=1, addr=0x0005, wdata=0xA5 -> cpu_ack next edge, mem_we=1, mem_addr=0x0005, one-cycle pulse.
REQ-031 Contention: x=140 (display slot), y=35, cpu_req read -> cycle x=140: mem_addr=0, cpu_ack=0; x=141: cpu_ack=1; x=142: cpu_rvalid=1.
REQ-032 Pixel path: RAM[160]=0x3C, y=39 (row 1) -> pix_out=0x3C for x=144..147, and pix_out=0 at x=784.
REQ-033 Out-of-range: cpu read addr=19200 -> cpu_ack then cpu_rvalid with cpu_rdata=0, mem_we=0 throughout.
REQ-034 Reset mid-read: rst pulsed the cycle after cpu_ack -> no cpu_rvalid; all outputs 0 while rst=1.
REQ-035 Full-frame: random CPU traffic over 2 frames -> every request acked within 2 cycles, and no display slot is ever missed.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the VRAM arbiter state encoding.
package vga_timing_pkg;

    localparam int VGA_H_START   = 144;
    localparam int VGA_V_START   = 35;
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int FB_W_DEFAULT  = 160;
    localparam int FB_H_DEFAULT  = 120;
    localparam int SCALE_DEFAULT = 2;

    localparam int ADDR_W = 15;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_e;

    // Which requester the RAM word arriving next cycle belongs to.
    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer row/column to linear address for a 160-pixel-wide buffer, shift-and-add only.
module fb_addr_gen
    import vga_timing_pkg::*;
(
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    output logic [ADDR_W-1:0] addr_o
);

    // row*160 = row*128 + row*32
    assign addr_o = (ADDR_W'(row_i) << 7) + (ADDR_W'(row_i) << 5) + ADDR_W'(col_i);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch slots have absolute priority, CPU gets the gaps.
module vram_arbiter
    import vga_timing_pkg::*;
#(
    parameter int H_START    = VGA_H_START,
    parameter int V_START    = VGA_V_START,
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int SCALE_LOG2 = SCALE_DEFAULT
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_out
);

    localparam int                LEAD       = 1 << SCALE_LOG2;
    localparam logic [9:0]        FETCH_X0   = 10'(H_START - LEAD);
    localparam logic [9:0]        FETCH_X1   = 10'(H_START + VGA_H_ACTIVE - LEAD);
    localparam logic [9:0]        ACT_X0     = 10'(H_START);
    localparam logic [9:0]        ACT_X1     = 10'(H_START + VGA_H_ACTIVE);
    localparam logic [9:0]        ACT_Y0     = 10'(V_START);
    localparam logic [9:0]        ACT_Y1     = 10'(V_START + VGA_V_ACTIVE);
    localparam logic [9:0]        PHASE_MASK = 10'(LEAD - 1);
    localparam logic [ADDR_W-1:0] FB_SIZE    = ADDR_W'(FB_W * FB_H);

    arb_state_e        state_q, state_d;
    owner_e            owner_q;
    logic              rd_pend_q;
    logic              oob_q;
    logic [7:0]        pend_q;
    logic [7:0]        pix_q;
    logic [7:0]        rdata_q;
    logic [7:0]        wdata_q;
    logic [ADDR_W-1:0] addr_q;

    logic [9:0]        fetch_phase, line_off, pix_phase;
    logic              in_lines, in_fetch, in_active, disp_slot, pix_load, cpu_oob;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] disp_addr;

    assign fetch_phase = x - FETCH_X0;
    assign line_off    = y - ACT_Y0;
    assign pix_phase   = x - ACT_X0;
    assign in_lines    = (y >= ACT_Y0) && (y < ACT_Y1);
    assign in_fetch    = in_lines && (x >= FETCH_X0) && (x < FETCH_X1);
    assign in_active   = in_lines && (x >= ACT_X0) && (x < ACT_X1);
    assign disp_slot   = in_fetch && ((fetch_phase & PHASE_MASK) == '0);
    assign pix_load    = in_active && ((pix_phase & PHASE_MASK) == '0);
    assign row         = ROW_W'(line_off >> SCALE_LOG2);
    assign col         = COL_W'(fetch_phase >> SCALE_LOG2);
    assign cpu_oob     = (cpu_addr >= FB_SIZE);

    fb_addr_gen u_addr_gen (
        .row_i  (row),
        .col_i  (col),
        .addr_o (disp_addr)
    );

    always_comb begin
        state_d    = ST_IDLE;
        cpu_ack    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        cpu_rvalid = 1'b0;
        cpu_rdata  = rdata_q;
        pix_out    = '0;

        // A grant in the previous cycle blocks this one so a held request is not served twice.
        if (rst)                                  state_d = ST_IDLE;
        else if (disp_slot)                       state_d = ST_DISP;
        else if (cpu_req && (state_q != ST_CPU))  state_d = ST_CPU;

        case (state_d)
            ST_DISP: mem_addr = disp_addr;
            ST_CPU: begin
                cpu_ack   = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we && !cpu_oob;
            end
            default: ;
        endcase

        if (rd_pend_q && (owner_q == OWN_CPU)) begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = oob_q ? 8'h00 : mem_rdata;
        end

        if (in_active) pix_out = pix_load ? pend_q : pix_q;
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_DISP;
            rd_pend_q <= 1'b0;
            oob_q     <= 1'b0;
            pend_q    <= '0;
            pix_q     <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= (state_d == ST_CPU) ? OWN_CPU : OWN_DISP;
            rd_pend_q <= (state_d == ST_DISP) || ((state_d == ST_CPU) && !cpu_we);
            oob_q     <= cpu_oob;
            pix_q     <= pix_out;
            rdata_q   <= cpu_rdata;
            wdata_q   <= mem_wdata;
            addr_q    <= mem_addr;
            if (rd_pend_q && (owner_q == OWN_DISP)) pend_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized CPU traffic against a frame-level model.
module tb_vram_arbiter;

    logic        clk_25mhz = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  pix_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment RAM: unwritten locations return a fixed address hash.
    bit [7:0] ram_d [0:32767];
    bit       ram_w [0:32767];
    // Reference copy of the framebuffer, updated only on granted in-range writes.
    bit [7:0] ref_d [0:32767];
    bit       ref_w [0:32767];

    always #20 clk_25mhz = ~clk_25mhz;

    vram_arbiter dut (
        .clk_25mhz  (clk_25mhz),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_out    (pix_out)
    );

    function automatic logic [7:0] seed8(input logic [14:0] a);
        logic [14:0] t;
        t = a ^ (a >> 7);
        return t[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_read(input int a);
        if (a >= 19200) return 8'h00;
        return ref_w[a] ? ref_d[a] : seed8(15'(a));
    endfunction

    always @(posedge clk_25mhz) begin
        if (mem_we) begin
            ram_d[mem_addr] <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_w[mem_addr] ? ram_d[mem_addr] : seed8(mem_addr);
    end

    task automatic next_cycle();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 10'd140; y = 10'd35;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hFF;
        repeat (3) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", cpu_rvalid); end
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); end
        n_checks++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 15'h0)  begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
        n_checks++; if (pix_out !== 8'h00)   begin n_fail++; $display("FAIL reset_pix got=%h exp=00", pix_out); end
        $display("txn reset: outputs held at zero");
        next_cycle();
        rst = 1'b0; cpu_req = 1'b0; x = 10'd0; y = 10'd10;
        next_cycle();
    endtask

    task automatic test_blank_write();
        x = 10'd300; y = 10'd10; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = 8'hA5;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1)      begin n_fail++; $display("FAIL blank_ack got=%b exp=1", cpu_ack); end
        n_checks++; if (mem_we !== 1'b1)       begin n_fail++; $display("FAIL blank_we got=%b exp=1", mem_we); end
        n_checks++; if (mem_addr !== 15'h0005) begin n_fail++; $display("FAIL blank_addr got=%h exp=0005", mem_addr); end
        n_checks++; if (mem_wdata !== 8'hA5)   begin n_fail++; $display("FAIL blank_wdata got=%h exp=a5", mem_wdata); end
        ref_d[5] = 8'hA5; ref_w[5] = 1'b1;
        next_cycle();
        x = 10'd301;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL blank_no_b2b got ack=%b we=%b exp ack=0 we=0", cpu_ack, mem_we);
        end
        next_cycle();
        x = 10'd302; cpu_req = 1'b0;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL blank_drop_ack got=%b exp=0", cpu_ack); end
        $display("txn blank write addr=0005 data=a5");
        next_cycle();
    endtask

    task automatic test_contention();
        x = 10'd140; y = 10'd35; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        @(negedge clk_25mhz);
        n_checks++; if (mem_addr !== 15'h0 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL cont_slot got addr=%h ack=%b we=%b exp addr=0 ack=0 we=0", mem_addr, cpu_ack, mem_we);
        end
        next_cycle();
        x = 10'd141;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1 || mem_addr !== 15'h0005) begin
            n_fail++; $display("FAIL cont_grant got ack=%b addr=%h exp ack=1 addr=0005", cpu_ack, mem_addr);
        end
        next_cycle();
        x = 10'd142; cpu_req = 1'b0;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_read(5)) begin
            n_fail++; $display("FAIL cont_rvalid got rv=%b data=%h exp rv=1 data=%h", cpu_rvalid, cpu_rdata, ref_read(5));
        end
        next_cycle();
        x = 10'd143;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_rvalid_once got=%b exp=0", cpu_rvalid); end
        next_cycle();
        x = 10'd144;
        @(negedge clk_25mhz);
        n_checks++; if (pix_out !== ref_read(0)) begin
            n_fail++; $display("FAIL cont_pix got=%h exp=%h", pix_out, ref_read(0));
        end
        $display("txn contention read addr=0005 data=%h", cpu_rdata);
        next_cycle();
    endtask

    task automatic test_pixel();
        x = 10'd400; y = 10'd10; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd160; cpu_wdata = 8'h3C;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL pix_write got ack=%b we=%b exp ack=1 we=1", cpu_ack, mem_we);
        end
        ref_d[160] = 8'h3C; ref_w[160] = 1'b1;
        next_cycle();
        cpu_req = 1'b0; y = 10'd39;
        for (int xi = 138; xi <= 150; xi++) begin
            x = 10'(xi);
            @(negedge clk_25mhz);
            if (xi < 144) begin
                n_checks++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL pix_pre x=%0d got=%h exp=00", xi, pix_out); end
            end else if (xi <= 147) begin
                n_checks++; if (pix_out !== 8'h3C) begin n_fail++; $display("FAIL pix_col0 x=%0d got=%h exp=3c", xi, pix_out); end
            end else begin
                n_checks++; if (pix_out !== ref_read(161)) begin
                    n_fail++; $display("FAIL pix_col1 x=%0d got=%h exp=%h", xi, pix_out, ref_read(161));
                end
            end
            next_cycle();
        end
        for (int xi = 784; xi <= 785; xi++) begin
            x = 10'(xi);
            @(negedge clk_25mhz);
            n_checks++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL pix_post x=%0d got=%h exp=00", xi, pix_out); end
            next_cycle();
        end
        $display("txn pixel row1 col0 = 3c");
    endtask

    task automatic test_oob();
        x = 10'd400; y = 10'd10; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd19200;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL oob_rd_ack got ack=%b we=%b exp ack=1 we=0", cpu_ack, mem_we);
        end
        next_cycle();
        x = 10'd401; cpu_req = 1'b0;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL oob_rd_data got rv=%b data=%h we=%b exp rv=1 data=00 we=0", cpu_rvalid, cpu_rdata, mem_we);
        end
        next_cycle();
        x = 10'd402; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd20000; cpu_wdata = 8'h77;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL oob_wr got ack=%b we=%b exp ack=1 we=0", cpu_ack, mem_we);
        end
        next_cycle();
        x = 10'd403; cpu_req = 1'b0;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL oob_wr_rvalid got=%b exp=0", cpu_rvalid); end
        $display("txn out-of-range read 19200 and write 20000");
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        x = 10'd500; y = 10'd10; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack got=%b exp=1", cpu_ack); end
        next_cycle();
        rst = 1'b1; x = 10'd501;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_25mhz);
            n_checks++; if (cpu_rvalid !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 8'h00) begin
                n_fail++; $display("FAIL rstmid_cpu got rv=%b ack=%b data=%h exp 0/0/00", cpu_rvalid, cpu_ack, cpu_rdata);
            end
            n_checks++; if (mem_we !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 8'h00 || pix_out !== 8'h00) begin
                n_fail++; $display("FAIL rstmid_mem got we=%b addr=%h wd=%h pix=%h exp zeros", mem_we, mem_addr, mem_wdata, pix_out);
            end
            next_cycle();
        end
        rst = 1'b0; x = 10'd503;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant got=%b exp=1", cpu_ack); end
        next_cycle();
        x = 10'd504; cpu_req = 1'b0;
        @(negedge clk_25mhz);
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_read(5)) begin
            n_fail++; $display("FAIL rstmid_rdata got rv=%b data=%h exp rv=1 data=%h", cpu_rvalid, cpu_rdata, ref_read(5));
        end
        $display("txn reset mid-read, re-arbitrated read data=%h", cpu_rdata);
        next_cycle();
    endtask

    task automatic test_random_frames();
        int         lines[$];
        logic [7:0] line_fetch [0:159];
        bit         active, t_we, exp_prev_ack, exp_rv, exp_ack, slot, vis_line, act_pix;
        int         t_addr, gap, waitcnt, exp_addr, limit, yv, n_txn;
        logic [7:0] t_wd, exp_rd, exp_pix;

        for (int l = 34; l <= 62; l++)   lines.push_back(l);
        for (int l = 513; l <= 516; l++) lines.push_back(l);
        active = 1'b0; t_we = 1'b0; t_addr = 0; t_wd = 8'h00; gap = 2; waitcnt = 0;
        exp_prev_ack = 1'b0; exp_rv = 1'b0; exp_rd = 8'h00; n_txn = 0;

        foreach (lines[li]) begin
            yv = lines[li];
            for (int xi = 0; xi < 800; xi++) begin
                x = 10'(xi); y = 10'(yv);
                if (!active) begin
                    if (gap > 0) gap--;
                    else begin
                        active  = 1'b1;
                        waitcnt = 0;
                        t_we    = ($urandom_range(0, 1) == 1);
                        t_wd    = 8'($urandom);
                        if ($urandom_range(0, 15) == 0)     t_addr = 19200 + int'($urandom_range(0, 13567));
                        else if ($urandom_range(0, 1) == 0) t_addr = int'($urandom_range(0, 1279));
                        else                                t_addr = int'($urandom_range(0, 19199));
                    end
                end
                cpu_req = active; cpu_we = t_we; cpu_addr = 15'(t_addr); cpu_wdata = t_wd;
                @(negedge clk_25mhz);

                vis_line = (yv >= 35) && (yv < 515);
                slot     = vis_line && (xi >= 140) && (xi < 780) && ((xi - 140) % 4 == 0);
                act_pix  = vis_line && (xi >= 144) && (xi < 784);
                exp_addr = ((yv - 35) / 4) * 160 + (xi - 140) / 4;
                exp_ack  = active && !slot && !exp_prev_ack;

                n_checks++; if (cpu_ack !== exp_ack) begin
                    n_fail++; $display("FAIL rnd_ack y=%0d x=%0d got=%b exp=%b", yv, xi, cpu_ack, exp_ack);
                end
                if (slot) begin
                    n_checks++; if (mem_addr !== 15'(exp_addr) || mem_we !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_slot y=%0d x=%0d got addr=%h we=%b exp addr=%h we=0", yv, xi, mem_addr, mem_we, 15'(exp_addr));
                    end
                    line_fetch[(xi - 140) / 4] = ref_read(exp_addr);
                end else if (exp_ack) begin
                    n_checks++; if (mem_addr !== 15'(t_addr) || mem_we !== (t_we && t_addr < 19200) || (t_we && mem_wdata !== t_wd)) begin
                        n_fail++; $display("FAIL rnd_grant y=%0d x=%0d got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                                           yv, xi, mem_addr, mem_we, mem_wdata, 15'(t_addr), t_we && t_addr < 19200, t_wd);
                    end
                end else begin
                    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_we y=%0d x=%0d got=%b exp=0", yv, xi, mem_we); end
                end

                n_checks++; if (cpu_rvalid !== exp_rv || (exp_rv && cpu_rdata !== exp_rd)) begin
                    n_fail++; $display("FAIL rnd_rvalid y=%0d x=%0d got rv=%b data=%h exp rv=%b data=%h", yv, xi, cpu_rvalid, cpu_rdata, exp_rv, exp_rd);
                end

                exp_pix = act_pix ? line_fetch[(xi - 144) / 4] : 8'h00;
                n_checks++; if (pix_out !== exp_pix) begin
                    n_fail++; $display("FAIL rnd_pix y=%0d x=%0d got=%h exp=%h", yv, xi, pix_out, exp_pix);
                end

                exp_rv = 1'b0;
                if (exp_ack) begin
                    limit = vis_line ? 2 : 1;
                    n_checks++; if (waitcnt > limit) begin
                        n_fail++; $display("FAIL rnd_wait y=%0d x=%0d got=%0d cycles exp<=%0d", yv, xi, waitcnt, limit);
                    end
                    if (t_we && t_addr < 19200) begin
                        ref_d[t_addr] = t_wd; ref_w[t_addr] = 1'b1;
                    end
                    if (!t_we) begin
                        exp_rv = 1'b1;
                        exp_rd = ref_read(t_addr);
                    end
                    $display("txn rnd %s addr=%0d data=%h wait=%0d", t_we ? "wr" : "rd", t_addr, t_we ? t_wd : exp_rd, waitcnt);
                    n_txn++;
                    active = 1'b0;
                    gap    = int'($urandom_range(0, 3));
                end else if (active) begin
                    waitcnt++;
                end
                exp_prev_ack = exp_ack;
                next_cycle();
            end
        end
        cpu_req = 1'b0;
        $display("random traffic: %0d transactions over %0d lines", n_txn, lines.size());
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_blank_write();
        test_contention();
        test_pixel();
        test_oob();
        test_reset_mid_read();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
